// File: rtl/e203_exu_fpu_fmis_sched_pkg.sv
// Shared definitions for the FPU sign-injection scheduler: op encodings,
// result-entry width and the sign-injection function.
package e203_exu_fpu_fmis_sched_pkg;

   localparam logic [1:0] FMIS_SGNJ  = 2'd0;
   localparam logic [1:0] FMIS_SGNJN = 2'd1;
   localparam logic [1:0] FMIS_SGNJX = 2'd2;
   localparam logic [1:0] FMIS_ILL   = 2'd3;

   // Entry layout, LSB first: wdat[31:0], itag, src, ill.
   function automatic int fmis_entry_w(input int itag_w);
      return 32 + itag_w + 2;
   endfunction

   function automatic logic [31:0] fmis_sgnj(input logic [31:0] rs1,
                                             input logic [31:0] rs2,
                                             input logic [1:0]  flag);
      logic sgn;
      case (flag)
         FMIS_SGNJ:  sgn = rs2[31];
         FMIS_SGNJN: sgn = ~rs2[31];
         FMIS_SGNJX: sgn = rs1[31] ^ rs2[31];
         default:    sgn = 1'b0;
      endcase
      return (flag == FMIS_ILL) ? 32'h0 : {sgn, rs1[30:0]};
   endfunction

endpackage

// File: rtl/e203_exu_fpu_fmis_rr_arb.sv
// Two-way round-robin arbiter: a lone valid wins, a tie goes to prio, and prio
// flips to the other requester after every accepted grant.
module e203_exu_fpu_fmis_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       space,
   output logic [1:0] grant,
   output logic       winner
);

   logic prio;
   logic accept;

   always_comb begin
      winner = prio;
      case (valid)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         default: winner = prio;
      endcase
   end

   assign grant  = {space & winner, space & ~winner};
   assign accept = |(grant & valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio <= 1'b0;
      end else if (accept) begin
         prio <= ~winner;
      end
   end

endmodule

// File: rtl/e203_exu_fpu_fmis_sched.sv
// Shares one FSGNJ/FSGNJN/FSGNJX datapath between two requesters and queues the
// results in a small FIFO toward FPU writeback.
module e203_exu_fpu_fmis_sched
   import e203_exu_fpu_fmis_sched_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ITAG_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [31:0]       r0_rs1,
   input  logic [31:0]       r0_rs2,
   input  logic [1:0]        r0_flag,
   input  logic [ITAG_W-1:0] r0_itag,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [31:0]       r1_rs1,
   input  logic [31:0]       r1_rs2,
   input  logic [1:0]        r1_flag,
   input  logic [ITAG_W-1:0] r1_itag,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [31:0]       o_wdat,
   output logic [ITAG_W-1:0] o_itag,
   output logic              o_src,
   output logic              o_ill,
   output logic              busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = fmis_entry_w(ITAG_W);
   localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [EW-1:0]     mem [DEPTH];
   logic [PW:0]       count;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic              space;
   logic [1:0]        grant;
   logic              winner;
   logic              push;
   logic              pop;
   logic [31:0]       sel_rs1;
   logic [31:0]       sel_rs2;
   logic [1:0]        sel_flag;
   logic [ITAG_W-1:0] sel_itag;
   logic [EW-1:0]     push_ent;
   logic [EW-1:0]     head;

   // Handshake: an op transfers on rX_valid & rX_ready, a result on o_valid &
   // o_ready. ready never depends on o_ready, and is held low during flush/rst.
   assign space = (count < DEPTH_C) & ~flush & ~rst;

   e203_exu_fpu_fmis_rr_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .valid  ({r1_valid, r0_valid}),
      .space  (space),
      .grant  (grant),
      .winner (winner)
   );

   assign r0_ready = grant[0];
   assign r1_ready = grant[1];
   assign push     = |(grant & {r1_valid, r0_valid});

   assign sel_rs1  = winner ? r1_rs1  : r0_rs1;
   assign sel_rs2  = winner ? r1_rs2  : r0_rs2;
   assign sel_flag = winner ? r1_flag : r0_flag;
   assign sel_itag = winner ? r1_itag : r0_itag;
   assign push_ent = {sel_flag == FMIS_ILL, winner, sel_itag,
                      fmis_sgnj(sel_rs1, sel_rs2, sel_flag)};

   assign head    = mem[rd_ptr];
   assign o_valid = (count != '0);
   assign busy    = o_valid;
   assign pop     = o_valid & o_ready & ~flush;

   // Payload is forced to zero while empty so downstream never sees stale data.
   assign o_wdat = o_valid ? head[31:0]          : 32'h0;
   assign o_itag = o_valid ? head[32 +: ITAG_W]  : '0;
   assign o_src  = o_valid & head[32 + ITAG_W];
   assign o_ill  = o_valid & head[33 + ITAG_W];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_ent;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_e203_exu_fpu_fmis_sched.sv
// Bench for the sign-injection scheduler: vector table, directed corner
// sequences, then random traffic against a queue-based reference model.
module tb_e203_exu_fpu_fmis_sched;

   localparam int DEPTH  = 2;
   localparam int ITAG_W = 3;
   localparam int EW     = 32 + ITAG_W + 2;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [1:0]  flag;
      logic [31:0] exp_wdat;
      logic        exp_ill;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              r0_valid, r1_valid;
   logic              r0_ready, r1_ready;
   logic [31:0]       r0_rs1, r0_rs2, r1_rs1, r1_rs2;
   logic [1:0]        r0_flag, r1_flag;
   logic [ITAG_W-1:0] r0_itag, r1_itag;
   logic              o_valid, o_ready;
   logic [31:0]       o_wdat;
   logic [ITAG_W-1:0] o_itag;
   logic              o_src, o_ill, busy;

   int            checks;
   int            failures;
   logic [EW-1:0] exp_q[$];
   logic          tie_next;
   vec_t          vecs[6];

   e203_exu_fpu_fmis_sched #(.DEPTH(DEPTH), .ITAG_W(ITAG_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .r0_valid (r0_valid),
      .r0_ready (r0_ready),
      .r0_rs1   (r0_rs1),
      .r0_rs2   (r0_rs2),
      .r0_flag  (r0_flag),
      .r0_itag  (r0_itag),
      .r1_valid (r1_valid),
      .r1_ready (r1_ready),
      .r1_rs1   (r1_rs1),
      .r1_rs2   (r1_rs2),
      .r1_flag  (r1_flag),
      .r1_itag  (r1_itag),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_wdat   (o_wdat),
      .o_itag   (o_itag),
      .o_src    (o_src),
      .o_ill    (o_ill),
      .busy     (busy)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_sgnj(input logic [31:0] rs1,
                                            input logic [31:0] rs2,
                                            input logic [1:0]  flag);
      logic [31:0] mag;
      int          s;
      mag = rs1 & 32'h7FFF_FFFF;
      if (flag == 2'd0)      s = int'(rs2[31]);
      else if (flag == 2'd1) s = 1 - int'(rs2[31]);
      else if (flag == 2'd2) s = (rs1[31] != rs2[31]) ? 1 : 0;
      else return 32'h0;
      return mag + (s != 0 ? 32'h8000_0000 : 32'h0);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      flush    = 1'b0;
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      r0_rs1   = 32'h0;
      r0_rs2   = 32'h0;
      r1_rs1   = 32'h0;
      r1_rs2   = 32'h0;
      r0_flag  = 2'd0;
      r1_flag  = 2'd0;
      r0_itag  = '0;
      r1_itag  = '0;
      o_ready  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One random cycle checked against the queue model; model state is advanced
   // to what it should hold after the coming rising edge.
   task automatic rand_cycle();
      logic          sp, w, acc;
      logic [EW-1:0] ent;
      @(negedge clk);
      r0_valid = 1'($urandom_range(0, 1));
      r1_valid = 1'($urandom_range(0, 1));
      r0_rs1   = $urandom;
      r0_rs2   = $urandom;
      r1_rs1   = $urandom;
      r1_rs2   = $urandom;
      r0_flag  = 2'($urandom_range(0, 3));
      r1_flag  = 2'($urandom_range(0, 3));
      r0_itag  = ITAG_W'($urandom_range(0, 7));
      r1_itag  = ITAG_W'($urandom_range(0, 7));
      o_ready  = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 15) == 0);
      #1;
      sp = (exp_q.size() < DEPTH) && !flush;
      if (r0_valid && !r1_valid)      w = 1'b0;
      else if (r1_valid && !r0_valid) w = 1'b1;
      else                            w = tie_next;
      if (r0_valid || r1_valid) begin
         chk("rnd_r0_ready", r0_ready, sp && !w);
         chk("rnd_r1_ready", r1_ready, sp && w);
      end
      chk("rnd_o_valid", o_valid, exp_q.size() > 0);
      chk("rnd_busy", busy, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         chk("rnd_o_wdat", o_wdat, exp_q[0][31:0]);
         chk("rnd_o_itag", o_itag, exp_q[0][32 +: ITAG_W]);
         chk("rnd_o_src", o_src, exp_q[0][32 + ITAG_W]);
         chk("rnd_o_ill", o_ill, exp_q[0][33 + ITAG_W]);
      end else begin
         chk("rnd_o_wdat_empty", o_wdat, 0);
      end
      acc = sp && (w ? r1_valid : r0_valid);
      if (w) ent = {r1_flag == 2'd3, 1'b1, r1_itag, ref_sgnj(r1_rs1, r1_rs2, r1_flag)};
      else   ent = {r0_flag == 2'd3, 1'b0, r0_itag, ref_sgnj(r0_rs1, r0_rs2, r0_flag)};
      if (flush) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0 && o_ready) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(ent);
      end
      if (acc) tie_next = !w;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      vecs[0] = '{32'h3F80_0000, 32'hC000_0000, 2'd0, 32'hBF80_0000, 1'b0};
      vecs[1] = '{32'hBF80_0000, 32'h8000_0000, 2'd1, 32'h3F80_0000, 1'b0};
      vecs[2] = '{32'hBF80_0000, 32'h8000_0000, 2'd2, 32'h3F80_0000, 1'b0};
      vecs[3] = '{32'hBF80_0000, 32'h8000_0000, 2'd3, 32'h0000_0000, 1'b1};
      vecs[4] = '{32'hBF80_0000, 32'h0000_0000, 2'd0, 32'h3F80_0000, 1'b0};
      vecs[5] = '{32'h4040_0000, 32'h0000_0000, 2'd1, 32'hC040_0000, 1'b0};

      // reset state
      idle_inputs();
      rst      = 1'b1;
      r0_valid = 1'b1;
      #1;
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_o_wdat", o_wdat, 0);
      chk("rst_o_itag", o_itag, 0);
      @(negedge clk);
      rst      = 1'b0;
      r0_valid = 1'b0;

      // vector table through requester 0
      foreach (vecs[i]) begin
         @(negedge clk);
         r0_valid = 1'b1;
         r0_rs1   = vecs[i].rs1;
         r0_rs2   = vecs[i].rs2;
         r0_flag  = vecs[i].flag;
         r0_itag  = ITAG_W'(i);
         o_ready  = 1'b0;
         #1 chk($sformatf("vec%0d_ready", i), r0_ready, 1);
         @(negedge clk);
         r0_valid = 1'b0;
         o_ready  = 1'b1;
         #1;
         chk($sformatf("vec%0d_o_valid", i), o_valid, 1);
         chk($sformatf("vec%0d_o_wdat", i), o_wdat, vecs[i].exp_wdat);
         chk($sformatf("vec%0d_o_ill", i), o_ill, vecs[i].exp_ill);
         chk($sformatf("vec%0d_o_src", i), o_src, 0);
         chk($sformatf("vec%0d_o_itag", i), o_itag, i);
         @(negedge clk);
         o_ready = 1'b0;
         #1 chk($sformatf("vec%0d_drained", i), o_valid, 0);
      end

      // round robin from reset, both requesters always valid
      do_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         r0_valid = 1'b1;
         r1_valid = 1'b1;
         r0_itag  = ITAG_W'((k + 1) / 2);
         r1_itag  = ITAG_W'(4 + k / 2);
         o_ready  = 1'b1;
         #1;
         chk($sformatf("rr%0d_r0_ready", k), r0_ready, (k % 2) == 0);
         chk($sformatf("rr%0d_r1_ready", k), r1_ready, (k % 2) == 1);
         if (k > 0) begin
            chk($sformatf("rr%0d_o_valid", k), o_valid, 1);
            chk($sformatf("rr%0d_o_src", k), o_src, (k - 1) % 2);
            chk($sformatf("rr%0d_o_itag", k), o_itag,
                ((k - 1) % 2 == 0) ? (k - 1) / 2 : 4 + (k - 1) / 2);
         end
      end
      @(negedge clk);
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      #1;
      chk("rr_last_src", o_src, 1);
      chk("rr_last_itag", o_itag, 6);
      @(negedge clk);
      o_ready = 1'b0;
      #1 chk("rr_drained", o_valid, 0);

      // full / backpressure
      @(negedge clk);
      r0_valid = 1'b1;
      r0_itag  = 3'd1;
      #1 chk("full_acc1", r0_ready, 1);
      @(negedge clk);
      r0_itag = 3'd2;
      #1 chk("full_acc2", r0_ready, 1);
      @(negedge clk);
      r0_itag = 3'd3;
      o_ready = 1'b1;
      #1;
      chk("full_stall", r0_ready, 0);
      chk("full_head1", o_itag, 1);
      chk("full_busy", busy, 1);
      @(negedge clk);
      o_ready = 1'b0;
      #1;
      chk("full_resume", r0_ready, 1);
      chk("full_head2", o_itag, 2);
      @(negedge clk);
      r0_valid = 1'b0;
      o_ready  = 1'b1;
      #1 chk("full_head2b", o_itag, 2);
      @(negedge clk);
      #1;
      chk("full_head3", o_itag, 3);
      chk("full_head3_valid", o_valid, 1);
      @(negedge clk);
      o_ready = 1'b0;
      #1 chk("full_drained", o_valid, 0);

      // flush with two queued entries
      @(negedge clk);
      r0_valid = 1'b1;
      r0_itag  = 3'd5;
      #1 chk("fl_acc1", r0_ready, 1);
      @(negedge clk);
      r0_itag = 3'd6;
      #1 chk("fl_acc2", r0_ready, 1);
      @(negedge clk);
      r0_valid = 1'b0;
      r1_valid = 1'b1;
      flush    = 1'b1;
      o_ready  = 1'b1;
      #1;
      chk("fl_r1_ready", r1_ready, 0);
      chk("fl_head_visible", o_valid, 1);
      chk("fl_head_itag", o_itag, 5);
      @(negedge clk);
      flush    = 1'b0;
      r1_valid = 1'b0;
      o_ready  = 1'b0;
      #1;
      chk("fl_o_valid", o_valid, 0);
      chk("fl_busy", busy, 0);
      @(negedge clk);
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      r1_itag  = 3'd7;
      #1;
      chk("fl_prio_r0", r0_ready, 0);
      chk("fl_prio_r1", r1_ready, 1);
      @(negedge clk);
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      o_ready  = 1'b1;
      #1;
      chk("fl_after_itag", o_itag, 7);
      chk("fl_after_src", o_src, 1);
      @(negedge clk);
      o_ready = 1'b0;

      // asynchronous reset between edges with one entry queued
      @(negedge clk);
      r0_valid = 1'b1;
      r0_itag  = 3'd2;
      #1 chk("ar_acc", r0_ready, 1);
      @(negedge clk);
      #1 chk("ar_queued", o_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_o_valid", o_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_r0_ready", r0_ready, 0);
      @(negedge clk);
      rst      = 1'b0;
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      #1;
      chk("ar_first_r0", r0_ready, 1);
      chk("ar_first_r1", r1_ready, 0);
      @(negedge clk);
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      o_ready  = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;

      // random traffic against the reference model
      do_reset();
      exp_q.delete();
      tie_next = 1'b0;
      for (int n = 0; n < 400; n++) begin
         rand_cycle();
      end
      @(negedge clk);
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
